pipeline_debug_controller: RTL and testbench
============================================

Name: pipeline_debug_controller

Overview:
- Sequences the 5-stage MIPS pipeline for debug: continuous run, single-step or halt, driven by command bytes from the UART receiver.
- After each stop, takes over debugMode/DebugAddress and streams a snapshot to the UART transmitter, MSB-first, 4 bytes per word: cycle count, register file, then data-memory words.
- Sits between the UART rx/tx and the Pipeline top; gates pipeline advance through a clock-enable.

Parameters:
MEM_DUMP_WORDS, 32, number of data-memory words dumped after the 32 registers (1..224)
REG_COUNT, 32, number of register-file entries dumped

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high
cmd_valid  input  1  one-cycle strobe, command byte present
cmd_data  input  8  command: 0x63 'c' run, 0x73 's' step, 0x68 'h' halt; other values ignored
halt_detected  input  1  HALT instruction in WB stage this cycle
pipe_en  output  1  pipeline advance enable
debugMode  output  1  selects debug read path in pipeline
DebugAddress  output  32  0..REG_COUNT-1 = register index; REG_COUNT+k = data-memory word k
dbg_data  input  32  read data for DebugAddress, valid the cycle after the address is driven
tx_valid  output  1  byte available to transmitter
tx_data  output  8  byte to transmit
tx_ready  input  1  transmitter accepts byte when tx_valid && tx_ready
cycle_count  output  32  pipeline cycles executed, saturating
busy  output  1  high in every state except IDLE and DONE

Behaviour:
- Reset (async): state IDLE; pipe_en=0, debugMode=0, DebugAddress=0, tx_valid=0, tx_data=0, cycle_count=0, busy=0; internal word/byte counters and shift register=0. Reset mid-run or mid-dump aborts immediately; no partial byte completes.
- States: IDLE, RUN, STEP, DUMP_ADDR, DUMP_WAIT, DUMP_BYTE, DONE.
- IDLE: 'c' -> RUN; 's' -> STEP; 'h' and others ignored.
- RUN: pipe_en=1 every cycle.
  - halt_detected=1 -> DUMP (end flag set); that cycle is still counted and pipe_en is 0 from the next cycle.
  - 'h' -> DUMP (end flag clear).
  - 'h' and halt_detected in the same cycle: halt_detected wins, end flag set.
  - 'c'/'s' ignored.
- STEP: pipe_en=1 for exactly one cycle, then DUMP. halt_detected in that cycle sets the end flag.
- cycle_count increments on every cycle with pipe_en=1; holds at 0xFFFFFFFF.
- Dump entry: snapshot cycle_count into shift register; word index=0; go directly to DUMP_BYTE. Word index w>=1 reads DebugAddress = w-1.
- DUMP_ADDR: drive DebugAddress, debugMode=1 -> DUMP_WAIT.
- DUMP_WAIT: capture dbg_data into shift register -> DUMP_BYTE.
- DUMP_BYTE:
  - tx_valid=1, tx_data=shift[31:24]; tx_data stays stable while tx_valid && !tx_ready.
  - On accept: shift left 8, byte count +1.
  - After the 4th accept: word index +1. If index = 1+REG_COUNT+MEM_DUMP_WORDS, exit to DONE when the end flag is set, else IDLE. Otherwise -> DUMP_ADDR.
  - tx_valid drops the cycle after the last accept.
- debugMode=1 from dump entry until the dump exits, including DUMP_BYTE; DebugAddress holds its last value and returns to 0 on exit.
- Total bytes per dump = 4*(1+REG_COUNT+MEM_DUMP_WORDS) = 260 at defaults.
- cmd_valid in DUMP_* or DONE is dropped, not queued.
- DONE: terminal; pipe_en=0, debugMode=0; leaves only on reset.
- pipe_en is never 1 while debugMode=1.

Test Plan:
- Reset, send 's' -> pipe_en high exactly 1 cycle; cycle_count=1; 260 bytes, first four 00 00 00 01; state IDLE after; busy=0.
- 's' three times -> cycle_count=3; third dump begins 00 00 00 03; DebugAddress walks 0..63 in each dump.
- 'c', assert halt_detected on 10th enabled cycle -> pipe_en low from 11th cycle; cycle_count=10; dump follows; end state DONE; a later 'c' produces no pipe_en.
- 'c', then 'h' and halt_detected in the same cycle -> DONE after dump, not IDLE.
- Dump with tx_ready held low 5 cycles per byte -> tx_data stable while stalled, no byte lost or duplicated; register word 5 bytes match dbg_data=0xDEADBEEF as DE AD BE EF.
- Assert reset during byte 100 of a dump -> next cycle all outputs 0, state IDLE; a subsequent 's' restarts the dump from word 0.

Source files
------------

// File: rtl/pipeline_debug_controller.sv
// -----------------------------------------------------------------------------
// pipeline_debug_controller
//
// Purpose: sequences the 5-stage MIPS pipeline for debug (continuous run,
// single step, halt) from UART command bytes. After every stop it takes over
// the pipeline debug read port and streams a snapshot, MSB-first, 4 bytes per
// word: cycle count, REG_COUNT registers, then MEM_DUMP_WORDS memory words.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset          in   asynchronous, active-high
//   cmd_valid      in   one-cycle strobe, command byte present
//   cmd_data[7:0]  in   'c' run, 's' step, 'h' halt; anything else ignored
//   halt_detected  in   HALT instruction in WB this cycle
//   pipe_en        out  pipeline advance enable
//   debugMode      out  selects the pipeline debug read path
//   DebugAddress   out  register index, or REG_COUNT+k for memory word k
//   dbg_data       in   read data, valid the cycle after DebugAddress
//   tx_valid       out  byte available to the transmitter
//   tx_data[7:0]   out  byte to transmit
//   tx_ready       in   transmitter accepts when tx_valid && tx_ready
//   cycle_count    out  enabled pipeline cycles, saturating
//   busy           out  high outside IDLE and DONE
// -----------------------------------------------------------------------------
module pipeline_debug_controller #(
    parameter int MEM_DUMP_WORDS = 32,
    parameter int REG_COUNT      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [7:0]  cmd_data,
    input  logic        halt_detected,
    output logic        pipe_en,
    output logic        debugMode,
    output logic [31:0] DebugAddress,
    input  logic [31:0] dbg_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [31:0] cycle_count,
    output logic        busy
);

    localparam int TOTAL_WORDS = 1 + REG_COUNT + MEM_DUMP_WORDS;
    localparam int IDX_W       = $clog2(TOTAL_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_WORDS - 1);

    localparam logic [7:0] CMD_RUN  = 8'h63;
    localparam logic [7:0] CMD_STEP = 8'h73;
    localparam logic [7:0] CMD_HALT = 8'h68;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        STEP      = 3'd2,
        DUMP_ADDR = 3'd3,
        DUMP_WAIT = 3'd4,
        DUMP_BYTE = 3'd5,
        DONE      = 3'd6
    } state_t;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            sat_inc = v;
        end else begin
            sat_inc = v + 32'd1;
        end
    endfunction

    state_t            state_r, next_state_s;
    logic [31:0]       cycle_count_r, cycle_next_s;
    logic [31:0]       shift_r;
    logic [31:0]       dbg_addr_r;
    logic [IDX_W-1:0]  word_idx_r;
    logic [1:0]        byte_cnt_r;
    logic              end_flag_r;
    logic              pipe_en_r, debug_mode_r, tx_valid_r, busy_r;
    logic              pipe_en_next_s, debug_mode_next_s, tx_valid_next_s, busy_next_s;
    logic              accept_s, word_done_s, dump_entry_s;

    assign accept_s     = tx_valid_r & tx_ready;
    assign word_done_s  = accept_s & (byte_cnt_r == 2'd3);
    assign dump_entry_s = ((state_r == RUN) || (state_r == STEP)) && (next_state_s == DUMP_BYTE);
    assign cycle_next_s = pipe_en_r ? sat_inc(cycle_count_r) : cycle_count_r;

    assign pipe_en      = pipe_en_r;
    assign debugMode    = debug_mode_r;
    assign DebugAddress = dbg_addr_r;
    assign tx_valid     = tx_valid_r;
    assign tx_data      = shift_r[31:24];
    assign cycle_count  = cycle_count_r;
    assign busy         = busy_r;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; commands outside IDLE/RUN are dropped.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid && (cmd_data == CMD_RUN)) begin
                    next_state_s = RUN;
                end else if (cmd_valid && (cmd_data == CMD_STEP)) begin
                    next_state_s = STEP;
                end else begin
                    next_state_s = IDLE;
                end
            end
            RUN: begin
                if (halt_detected || (cmd_valid && (cmd_data == CMD_HALT))) begin
                    next_state_s = DUMP_BYTE;
                end else begin
                    next_state_s = RUN;
                end
            end
            STEP:      next_state_s = DUMP_BYTE;
            DUMP_ADDR: next_state_s = DUMP_WAIT;
            DUMP_WAIT: next_state_s = DUMP_BYTE;
            DUMP_BYTE: begin
                if (word_done_s && (word_idx_r == LAST_IDX)) begin
                    next_state_s = end_flag_r ? DONE : IDLE;
                end else if (word_done_s) begin
                    next_state_s = DUMP_ADDR;
                end else begin
                    next_state_s = DUMP_BYTE;
                end
            end
            DONE:    next_state_s = DONE;
            default: next_state_s = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the outputs can be registered
    // yet line up with the state they describe.
    always_comb begin
        pipe_en_next_s    = 1'b0;
        debug_mode_next_s = 1'b0;
        tx_valid_next_s   = 1'b0;
        busy_next_s       = 1'b0;
        case (next_state_s)
            RUN, STEP: begin
                pipe_en_next_s = 1'b1;
                busy_next_s    = 1'b1;
            end
            DUMP_ADDR, DUMP_WAIT: begin
                debug_mode_next_s = 1'b1;
                busy_next_s       = 1'b1;
            end
            DUMP_BYTE: begin
                debug_mode_next_s = 1'b1;
                tx_valid_next_s   = 1'b1;
                busy_next_s       = 1'b1;
            end
            default: begin
                pipe_en_next_s    = 1'b0;
                debug_mode_next_s = 1'b0;
                tx_valid_next_s   = 1'b0;
                busy_next_s       = 1'b0;
            end
        endcase
    end

    // Registered control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_en_r    <= 1'b0;
            debug_mode_r <= 1'b0;
            tx_valid_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            pipe_en_r    <= pipe_en_next_s;
            debug_mode_r <= debug_mode_next_s;
            tx_valid_r   <= tx_valid_next_s;
            busy_r       <= busy_next_s;
        end
    end

    // Cycle counter, snapshot shift register, word/byte counters, debug address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count_r <= 32'd0;
            shift_r       <= 32'd0;
            dbg_addr_r    <= 32'd0;
            word_idx_r    <= '0;
            byte_cnt_r    <= 2'd0;
            end_flag_r    <= 1'b0;
        end else begin
            cycle_count_r <= cycle_next_s;

            // The snapshot must include the final enabled cycle, which is
            // being counted on this same edge.
            if (dump_entry_s) begin
                shift_r    <= cycle_next_s;
                word_idx_r <= '0;
                byte_cnt_r <= 2'd0;
                end_flag_r <= halt_detected;
            end else if (state_r == DUMP_WAIT) begin
                shift_r <= dbg_data;
            end else if ((state_r == DUMP_BYTE) && accept_s) begin
                shift_r    <= {shift_r[23:0], 8'h00};
                byte_cnt_r <= byte_cnt_r + 2'd1;
                if (word_done_s && (word_idx_r == LAST_IDX)) begin
                    word_idx_r <= '0;
                end else if (word_done_s) begin
                    word_idx_r <= word_idx_r + IDX_W'(1);
                end else begin
                    word_idx_r <= word_idx_r;
                end
            end else begin
                shift_r <= shift_r;
            end

            // Word index w>=1 reads address w-1, i.e. the index before increment.
            if ((state_r == DUMP_BYTE) && (next_state_s == DUMP_ADDR)) begin
                dbg_addr_r <= 32'(word_idx_r);
            end else if ((next_state_s == IDLE) || (next_state_s == DONE)) begin
                dbg_addr_r <= 32'd0;
            end else begin
                dbg_addr_r <= dbg_addr_r;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_debug_controller.sv
module tb_pipeline_debug_controller;

    localparam int TOTAL_BYTES = 4 * (1 + 32 + 32);

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic        halt_detected = 1'b0;
    logic        pipe_en;
    logic        debugMode;
    logic [31:0] DebugAddress;
    logic [31:0] dbg_data = 32'd0;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic [31:0] cycle_count;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_debug_controller #(.MEM_DUMP_WORDS(32), .REG_COUNT(32)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .halt_detected(halt_detected), .pipe_en(pipe_en), .debugMode(debugMode),
        .DebugAddress(DebugAddress), .dbg_data(dbg_data), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_ready(tx_ready), .cycle_count(cycle_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pipeline debug read port: data for an address appears one cycle later.
    function automatic logic [31:0] mem_val(input logic [31:0] a);
        if (a == 32'd5) return 32'hDEAD_BEEF;
        return {a[7:0] ^ 8'hA5, a[7:0], 8'h3C, ~a[7:0]};
    endfunction

    always @(posedge clk) dbg_data <= mem_val(DebugAddress);

    task automatic do_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_data = 8'h00;
        halt_detected = 1'b0; tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = c;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = 8'h00;
    endtask

    task automatic check_all_zero(input string tag);
        n_tests++;
        if ({pipe_en, debugMode, tx_valid, busy} !== 4'b0000 || DebugAddress !== 32'd0 ||
            tx_data !== 8'h00 || cycle_count !== 32'd0) begin
            n_fail++;
            $display("FAIL %s: pe=%b dm=%b tv=%b busy=%b addr=%h txd=%h cc=%h, all required 0",
                     tag, pipe_en, debugMode, tx_valid, busy, DebugAddress, tx_data, cycle_count);
        end
    endtask

    // Counts enabled cycles until the dump takes over (bounded).
    task automatic wait_dump_start(output int en_cycles);
        bit seen = 1'b0;
        en_cycles = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (debugMode) seen = 1'b1;
            else begin
                if (pipe_en) en_cycles++;
                @(negedge clk);
            end
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL dump_start: debugMode never rose within 200 cycles, required 1");
        end
    endtask

    // Receives a whole dump, stalling tx_ready for 'stall' cycles per byte.
    task automatic collect_dump(input int stall, input logic [31:0] exp_cyc, input string tag);
        int nbytes = 0;
        int sc = 0;
        int guard = 0;
        int w, b;
        logic [31:0] v;
        logic [7:0] expb;
        while (nbytes < TOTAL_BYTES && guard < 6000) begin
            if (pipe_en && debugMode) begin
                n_tests++; n_fail++;
                $display("FAIL %s pe_dm_overlap: pipe_en=1 with debugMode=1, required exclusive", tag);
            end
            if (tx_valid) begin
                w = nbytes / 4; b = nbytes % 4;
                v = (w == 0) ? exp_cyc : mem_val(32'(w - 1));
                expb = 8'(v >> (24 - 8 * b));
                n_tests++;
                if (tx_data !== expb) begin
                    n_fail++;
                    if (n_fail < 30)
                        $display("FAIL %s byte%0d%s: got %h, required %h", tag, nbytes,
                                 (sc < stall) ? "_stalled" : "", tx_data, expb);
                end
                if (sc < stall) begin
                    tx_ready = 1'b0; sc++;
                end else begin
                    tx_ready = 1'b1; sc = 0;
                    if (b == 0) begin
                        n_tests++;
                        if (DebugAddress !== ((w == 0) ? 32'd0 : 32'(w - 1)) || debugMode !== 1'b1 || busy !== 1'b1) begin
                            n_fail++;
                            $display("FAIL %s addr_word%0d: addr=%0d dm=%b busy=%b, required addr=%0d dm=1 busy=1",
                                     tag, w, DebugAddress, debugMode, busy, (w == 0) ? 0 : w - 1);
                        end
                    end
                    nbytes++;
                end
            end else begin
                tx_ready = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        tx_ready = 1'b0;
        n_tests++;
        if (nbytes != TOTAL_BYTES) begin
            n_fail++;
            $display("FAIL %s byte_count: got %0d bytes before timeout, required %0d", tag, nbytes, TOTAL_BYTES);
        end
        n_tests++;
        if (tx_valid !== 1'b0 || debugMode !== 1'b0 || DebugAddress !== 32'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s dump_exit: tv=%b dm=%b addr=%0d busy=%b, required all 0",
                     tag, tx_valid, debugMode, DebugAddress, busy);
        end
    endtask

    // Run with 'c'; on the n-th enabled cycle raise halt and/or send 'h'.
    task automatic run_and_stop(input int n, input bit use_halt, input bit use_h, input string tag);
        int en = 0;
        bit done = 1'b0;
        send_cmd(8'h63);
        for (int g = 0; g < 200 && !done; g++) begin
            if (pipe_en) begin
                en++;
                if (en == n) begin
                    halt_detected = use_halt;
                    cmd_valid = use_h; cmd_data = use_h ? 8'h68 : 8'h00;
                    done = 1'b1;
                end
            end
            @(negedge clk);
        end
        halt_detected = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00;
        n_tests++;
        if (pipe_en !== 1'b0 || debugMode !== 1'b1 || cycle_count !== 32'(n)) begin
            n_fail++;
            $display("FAIL %s stop: pe=%b dm=%b cc=%0d, required pe=0 dm=1 cc=%0d",
                     tag, pipe_en, debugMode, cycle_count, n);
        end
    endtask

    // Sends 'c' and reports whether the pipeline advances within 5 cycles.
    task automatic probe_run(input bit expect_run, input string tag);
        bit ran = 1'b0;
        send_cmd(8'h63);
        for (int i = 0; i < 5; i++) begin
            if (pipe_en) ran = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (ran !== expect_run) begin
            n_fail++;
            $display("FAIL %s probe_run: pipe_en seen=%b, required %b", tag, ran, expect_run);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_step();
        int en;
        do_reset();
        send_cmd(8'h73);
        wait_dump_start(en);
        n_tests++;
        if (en != 1 || cycle_count !== 32'd1) begin
            n_fail++;
            $display("FAIL step_enable: en_cycles=%0d cc=%0d, required 1 and 1", en, cycle_count);
        end
        collect_dump(0, 32'd1, "step");
        probe_run(1'b1, "step_ends_idle");
    endtask

    task automatic test_back_to_back_steps();
        int en;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            send_cmd(8'h73);
            wait_dump_start(en);
            n_tests++;
            if (en != 1) begin
                n_fail++;
                $display("FAIL step%0d_enable: en_cycles=%0d, required 1", k, en);
            end
            collect_dump(0, 32'(k), "step3");
        end
        n_tests++;
        if (cycle_count !== 32'd3) begin
            n_fail++;
            $display("FAIL step3_count: got %0d, required 3", cycle_count);
        end
    endtask

    task automatic test_halt_run();
        do_reset();
        run_and_stop(10, 1'b1, 1'b0, "halt");
        collect_dump(0, 32'd10, "halt");
        probe_run(1'b0, "halt_done");
        n_tests++;
        if (cycle_count !== 32'd10) begin
            n_fail++;
            $display("FAIL halt_done_count: got %0d, required 10", cycle_count);
        end
    endtask

    task automatic test_halt_and_h();
        do_reset();
        run_and_stop(4, 1'b1, 1'b1, "h_halt");
        collect_dump(0, 32'd4, "h_halt");
        probe_run(1'b0, "h_halt_done");
    endtask

    task automatic test_cmd_halt();
        do_reset();
        run_and_stop(3, 1'b0, 1'b1, "cmd_h");
        collect_dump(0, 32'd3, "cmd_h");
        probe_run(1'b1, "cmd_h_idle");
    endtask

    task automatic test_stall();
        int en;
        do_reset();
        send_cmd(8'h73);
        wait_dump_start(en);
        collect_dump(5, 32'd1, "stall");
    endtask

    task automatic test_reset_mid_dump();
        int en;
        int nb = 0;
        bit hit = 1'b0;
        do_reset();
        send_cmd(8'h73);
        wait_dump_start(en);
        for (int g = 0; g < 2000 && !hit; g++) begin
            if (tx_valid && nb == 100) hit = 1'b1;
            else begin
                if (tx_valid) nb++;
                tx_ready = 1'b1;
                @(negedge clk);
            end
        end
        tx_ready = 1'b0;
        n_tests++;
        if (!hit) begin
            n_fail++;
            $display("FAIL midreset_reach: reached byte %0d, required 100", nb);
        end
        reset = 1'b1;
        #1;
        check_all_zero("midreset_async");
        @(negedge clk);
        check_all_zero("midreset_next");
        reset = 1'b0;
        send_cmd(8'h73);
        wait_dump_start(en);
        collect_dump(0, 32'd1, "after_midreset");
    endtask

    initial begin
        test_reset();
        test_step();
        test_back_to_back_steps();
        test_halt_run();
        test_halt_and_h();
        test_cmd_halt();
        test_stall();
        test_reset_mid_dump();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
